// File: rtl/riscv_pkg.sv
// Shared control-path definitions for the multicycle RISC-V core:
// FSM states, opcodes, ALU operation codes and immediate formats.
package riscv_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTER,
        ALUWB,
        EXECUTEI,
        JAL,
        BEQ
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic is_supported(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I) || (op == OP_JAL) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/main_fsm_if.sv
// Instruction fields and status in, datapath control strobes out.
// The controller takes the master view; the datapath takes the slave view.
interface main_fsm_if;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;

    logic [1:0] immsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       adrsrc;
    logic [2:0] alucontrol;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic       memwrite;
    logic       retire;

    modport master (
        input  op, funct3, funct7b5, zero,
        output immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
               irwrite, pcwrite, regwrite, memwrite, retire
    );

    modport slave (
        output op, funct3, funct7b5, zero,
        input  immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
               irwrite, pcwrite, regwrite, memwrite, retire
    );

endinterface

// File: rtl/main_fsm_alu_dec.sv
// ALU decoder: maps the FSM's coarse aluop plus instruction fields onto
// a concrete ALU operation.
module alu_dec
    import riscv_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        unique case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type distinguishes sub; addi never has op[5] set.
                    3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/main_fsm.sv
// Multicycle RISC-V main controller: Moore FSM sequencing fetch, decode,
// execute and writeback, plus the immediate-format decode.
module main_fsm
    import riscv_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    main_fsm_if.master    bus
);

    state_t     state;
    state_t     next_state;
    aluop_t     aluop;
    logic       pcupdate;
    logic       branch;
    logic [1:0] immsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       adrsrc;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       retire;

    // NOTE: state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            FETCH: next_state = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_R:         next_state = EXECUTER;
                    OP_I:         next_state = EXECUTEI;
                    OP_JAL:       next_state = JAL;
                    OP_BEQ:       next_state = BEQ;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR:   next_state = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  next_state = MEMWB;
            EXECUTER, EXECUTEI, JAL: next_state = ALUWB;
            MEMWB, MEMWRITE, ALUWB, BEQ: next_state = FETCH;
            default:  next_state = FETCH;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        alusrca   = 2'b00;
        alusrcb   = 2'b00;
        resultsrc = 2'b00;
        adrsrc    = 1'b0;
        irwrite   = 1'b0;
        regwrite  = 1'b0;
        memwrite  = 1'b0;
        retire    = 1'b0;
        pcupdate  = 1'b0;
        branch    = 1'b0;
        aluop     = ALUOP_ADD;
        if (reset) begin
            // Datapath muxes sit at their FETCH setting; all write strobes stay quiet.
            alusrcb   = 2'b10;
            resultsrc = 2'b10;
        end else begin
            unique case (state)
                FETCH: begin
                    irwrite   = 1'b1;
                    pcupdate  = 1'b1;
                    alusrcb   = 2'b10;
                    resultsrc = 2'b10;
                end
                DECODE: begin
                    alusrca = 2'b01;
                    alusrcb = 2'b01;
                    retire  = !is_supported(bus.op);
                end
                MEMADR: begin
                    alusrca = 2'b10;
                    alusrcb = 2'b01;
                end
                MEMREAD: adrsrc = 1'b1;
                MEMWB: begin
                    resultsrc = 2'b01;
                    regwrite  = 1'b1;
                    retire    = 1'b1;
                end
                MEMWRITE: begin
                    adrsrc   = 1'b1;
                    memwrite = 1'b1;
                    retire   = 1'b1;
                end
                EXECUTER: begin
                    alusrca = 2'b10;
                    aluop   = ALUOP_FUNCT;
                end
                EXECUTEI: begin
                    alusrca = 2'b10;
                    alusrcb = 2'b01;
                    aluop   = ALUOP_FUNCT;
                end
                JAL: begin
                    alusrca  = 2'b01;
                    alusrcb  = 2'b10;
                    pcupdate = 1'b1;
                end
                ALUWB: begin
                    regwrite = 1'b1;
                    retire   = 1'b1;
                end
                BEQ: begin
                    alusrca = 2'b10;
                    aluop   = ALUOP_SUB;
                    branch  = 1'b1;
                    retire  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (bus.op)
            OP_SW:   immsrc = IMM_S;
            OP_BEQ:  immsrc = IMM_B;
            OP_JAL:  immsrc = IMM_J;
            default: immsrc = IMM_I;
        endcase
    end

    alu_dec u_alu_dec (
        .aluop      (aluop),
        .funct3     (bus.funct3),
        .op5        (bus.op[5]),
        .funct7b5   (bus.funct7b5),
        .alucontrol (bus.alucontrol)
    );

    assign bus.immsrc    = immsrc;
    assign bus.alusrca   = alusrca;
    assign bus.alusrcb   = alusrcb;
    assign bus.resultsrc = resultsrc;
    assign bus.adrsrc    = adrsrc;
    assign bus.irwrite   = irwrite;
    assign bus.pcwrite   = pcupdate | (branch & bus.zero);
    assign bus.regwrite  = regwrite;
    assign bus.memwrite  = memwrite;
    assign bus.retire    = retire;

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm: directed instruction sequences followed by
// random instruction streams, compared cycle by cycle against a per-instruction table.
module tb_main_fsm;

    typedef struct packed {
        logic [1:0] immsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       adrsrc;
        logic [2:0] alucontrol;
        logic       irwrite;
        logic       pcwrite;
        logic       regwrite;
        logic       memwrite;
        logic       retire;
    } obs_t;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    main_fsm_if bus ();

    main_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int latency(input logic [6:0] op);
        case (op)
            LW:              return 5;
            SW, RT, IT, JL:  return 4;
            BQ:              return 3;
            default:         return 2;
        endcase
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] op);
        case (op)
            SW:      return 2'b01;
            BQ:      return 2'b10;
            JL:      return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Operation chosen by funct3 for R/I arithmetic: add/sub, slt, or, and.
    function automatic logic [2:0] exp_arith(input logic [6:0] op, input logic [2:0] f3,
                                             input logic f7);
        case (f3)
            3'd0:    return (op[5] && f7) ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected outputs in cycle k (0 = fetch) of one instruction.
    function automatic obs_t model(input logic [6:0] op, input logic [2:0] f3,
                                   input logic f7, input logic z, input int k);
        obs_t e;
        e = '0;
        e.immsrc = exp_imm(op);
        if (k == 0) begin
            e.irwrite = 1; e.pcwrite = 1; e.alusrcb = 2'b10; e.resultsrc = 2'b10;
        end else if (k == 1) begin
            e.alusrca = 2'b01; e.alusrcb = 2'b01;
            e.retire  = (latency(op) == 2);
        end else if (k == latency(op) - 1) begin
            case (op)
                BQ: begin
                    e.alusrca = 2'b10; e.alucontrol = 3'b001;
                    e.pcwrite = z; e.retire = 1;
                end
                LW: begin e.resultsrc = 2'b01; e.regwrite = 1; e.retire = 1; end
                SW: begin e.adrsrc = 1; e.memwrite = 1; e.retire = 1; end
                default: begin e.regwrite = 1; e.retire = 1; end
            endcase
        end else if (k == 2) begin
            case (op)
                LW, SW: begin e.alusrca = 2'b10; e.alusrcb = 2'b01; end
                RT: begin e.alusrca = 2'b10; e.alucontrol = exp_arith(op, f3, f7); end
                IT: begin
                    e.alusrca = 2'b10; e.alusrcb = 2'b01;
                    e.alucontrol = exp_arith(op, f3, f7);
                end
                JL: begin e.alusrca = 2'b01; e.alusrcb = 2'b10; e.pcwrite = 1; end
                default: ;
            endcase
        end else begin
            e.adrsrc = 1;   // the memory read cycle of lw
        end
        return e;
    endfunction

    function automatic obs_t reset_view(input logic [6:0] op);
        obs_t e;
        e = '0;
        e.immsrc = exp_imm(op); e.alusrcb = 2'b10; e.resultsrc = 2'b10;
        return e;
    endfunction

    task automatic check(input string tag, input obs_t expected);
        obs_t got;
        got = '{bus.immsrc, bus.alusrca, bus.alusrcb, bus.resultsrc, bus.adrsrc,
                bus.alucontrol, bus.irwrite, bus.pcwrite, bus.regwrite, bus.memwrite,
                bus.retire};
        checks++;
        assert (got === expected) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, expected);
        end
    endtask

    // Drives one instruction through all its cycles; zmode<0 randomizes zero.
    // abort_at>=0 raises reset in that cycle and checks the reset outputs instead.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input int zmode, input int abort_at);
        int n;
        n = latency(op);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.op       = op;
            bus.funct3   = f3;
            bus.funct7b5 = f7;
            bus.zero     = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            if (k == abort_at) begin
                reset = 1'b1;
                #1;
                check($sformatf("reset op=%b k=%0d", op, k), reset_view(op));
                return;
            end
            reset = 1'b0;
            #1;
            check($sformatf("op=%b f3=%0d f7=%b z=%b k=%0d", op, f3, f7, bus.zero, k),
                  model(op, f3, f7, bus.zero, k));
        end
    endtask

    logic [6:0] op_pool [7] = '{LW, SW, RT, IT, JL, BQ, BAD};

    initial begin
        logic [6:0] op;
        int         ab;
        reset        = 1'b1;
        bus.op       = 7'd0;
        bus.funct3   = 3'd0;
        bus.funct7b5 = 1'b0;
        bus.zero     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset hold", reset_view(7'd0));

        run_instr(LW, 3'd2, 1'b0, -1, -1);
        run_instr(RT, 3'd0, 1'b1, -1, -1);
        run_instr(BQ, 3'd0, 1'b0, 1, -1);
        run_instr(BQ, 3'd0, 1'b0, 0, -1);
        run_instr(JL, 3'd5, 1'b1, -1, -1);
        run_instr(BAD, 3'd0, 1'b0, -1, -1);
        run_instr(SW, 3'd2, 1'b0, -1, 3);
        run_instr(IT, 3'd0, 1'b1, -1, -1);
        run_instr(RT, 3'd7, 1'b0, -1, -1);

        for (int i = 0; i < 80; i++) begin
            op = ($urandom_range(0, 7) == 7) ? 7'($urandom) : op_pool[$urandom_range(0, 6)];
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, latency(op) - 1) : -1;
            run_instr(op, 3'($urandom), 1'($urandom), -1, ab);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
